// File: rtl/store_write_buffer.sv
// Store-side MEM-stage buffer: packs sb/sh/sw data onto byte lanes, flags misaligned stores,
// and queues packed writes in a small FIFO drained to data memory over a req/ack handshake.
module store_write_buffer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_mode,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_misalign,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        buf_empty
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      addr_d  [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [31:0]      wdata_d [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [3:0]       be_d    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             misalign_q, misalign_d;

  logic        mis, fire, push, pop;
  logic [31:0] pk_addr, pk_wdata;
  logic [3:0]  pk_be;

  assign st_ready    = (cnt_q != FULL);
  assign mem_req     = (cnt_q != '0);
  assign buf_empty   = (cnt_q == '0);
  assign st_misalign = misalign_q;
  assign mem_addr    = addr_q[rd_ptr_q];
  assign mem_wdata   = wdata_q[rd_ptr_q];
  assign mem_be      = be_q[rd_ptr_q];

  always_comb begin
    mis  = ((st_mode == 2'b10) && st_addr[0]) ||
           ((st_mode == 2'b11) && (st_addr[1:0] != 2'b00));
    fire = st_valid && st_ready && (st_mode != 2'b00);
    push = fire && !mis;
    pop  = mem_req && mem_ack;

    pk_addr  = {st_addr[31:2], 2'b00};
    pk_wdata = st_data;
    pk_be    = 4'b1111;
    case (st_mode)
      2'b01: begin
        pk_wdata = {4{st_data[7:0]}};
        pk_be    = 4'b0001 << st_addr[1:0];
      end
      2'b10: begin
        pk_wdata = {2{st_data[15:0]}};
        pk_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase

    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (push) begin
      addr_d[wr_ptr_q]  = pk_addr;
      wdata_d[wr_ptr_q] = pk_wdata;
      be_d[wr_ptr_q]    = pk_be;
    end

    // Pointers are PTR_W wide, so the increment wraps modulo DEPTH.
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop && !push)
      cnt_d = cnt_q - 1'b1;

    misalign_d = fire && mis;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
